led_scan_module: RTL

LED_SCAN_MODULE -- requirements
Module: led_scan_module

---
 rtl/led_scan_module_pkg.sv | 29 ++
 rtl/scan_tick_gen.sv | 37 +++
 rtl/led_scan_module.sv | 68 ++++++
 3 files changed

// File: rtl/led_scan_module_pkg.sv
// Shared constants and helpers for the multiplexed LED scan display.
// Column and row drives are active-low throughout.
package led_scan_module_pkg;

  localparam int NUM_COLS  = 4;
  localparam int ROW_BITS  = 8;
  localparam int COL_IDX_W = $clog2(NUM_COLS);

  localparam logic                COL_ON    = 1'b0;
  localparam logic                LED_ON    = 1'b0;
  localparam logic [NUM_COLS-1:0] COL_BLANK = 4'b1111;
  localparam logic [ROW_BITS-1:0] LED_BLANK = 8'hFF;

  typedef logic [COL_IDX_W-1:0] col_idx_t;
  typedef logic [ROW_BITS-1:0]  row_t;

  // Active-low one-hot select for a single column.
  function automatic logic [NUM_COLS-1:0] col_select(input col_idx_t idx);
    logic [NUM_COLS-1:0] onehot;
    onehot      = '0;
    onehot[idx] = 1'b1;
    return ~onehot;
  endfunction

  function automatic row_t row_drive(input row_t pattern);
    return ~pattern;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Dwell counter and column scan index; raises o_blank for the first
// BLANK_CYCLES counts of every column dwell.
module scan_tick_gen
  import led_scan_module_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 12000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  output col_idx_t o_scan_col,
  output logic     o_blank
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  col_idx_t         r_scan_col;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_scan_col <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt      <= '0;
      r_scan_col <= r_scan_col + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_scan_col = r_scan_col;
  assign o_blank    = (r_cnt < BLANK_END);

endmodule

// File: rtl/led_scan_module.sv
// Four-column LED matrix scanner: a 4-byte frame buffer fed by a byte
// stream, displayed one column per dwell with a blanking gap.
module led_scan_module
  import led_scan_module_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 12000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                top_clk,
  input  logic                rst_n,
  input  logic [ROW_BITS-1:0] byte_in,
  input  logic                byte_valid,
  output logic [ROW_BITS-1:0] led,
  output logic [NUM_COLS-1:0] col,
  output logic                frame_done
);

  col_idx_t            w_scan_col;
  logic                w_blank;

  row_t                r_frame [NUM_COLS];
  col_idx_t            r_wr_ptr;
  logic [ROW_BITS-1:0] r_led;
  logic [NUM_COLS-1:0] r_col;
  logic                r_frame_done;

  scan_tick_gen #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan_tick_gen (
    .i_clk      (top_clk),
    .i_rst_n    (rst_n),
    .o_scan_col (w_scan_col),
    .o_blank    (w_blank)
  );

  // Output registers read the frame before this edge's write, so a new
  // byte reaches the rows exactly one cycle after it is stored.
  always_ff @(posedge top_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        r_frame[i] <= '0;
      end
      r_wr_ptr     <= '0;
      r_led        <= LED_BLANK;
      r_col        <= COL_BLANK;
      r_frame_done <= 1'b0;
    end else begin
      if (byte_valid) begin
        r_frame[r_wr_ptr] <= byte_in;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      r_frame_done <= byte_valid && (r_wr_ptr == col_idx_t'(NUM_COLS - 1));
      if (w_blank) begin
        r_led <= LED_BLANK;
        r_col <= COL_BLANK;
      end else begin
        r_led <= row_drive(r_frame[w_scan_col]);
        r_col <= col_select(w_scan_col);
      end
    end
  end

  assign led        = r_led;
  assign col        = r_col;
  assign frame_done = r_frame_done;

endmodule
